// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FUNC3 encodings,
// FSM states, byte-lane masks and FUNC3 normalisation helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Collapse encodings the unit does not recognise onto a full-word access.
  function automatic logic [2:0] norm_func3(input logic is_store, input logic [2:0] f3);
    logic [2:0] r;
    r = F3_W;
    if (is_store) begin
      if (f3 == F3_B || f3 == F3_H) r = f3;
    end else begin
      if (f3 == F3_B || f3 == F3_H || f3 == F3_BU || f3 == F3_HU) r = f3;
    end
    return r;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = STRB_B;
      F3_H, F3_HU: m = STRB_H;
      default:     m = STRB_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends a load result from the (up to) two memory words an
// access touched, given the byte offset and the access FUNC3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] high_i,
  input  logic [31:0] low_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [63:0] combined;
  logic [31:0] shifted;

  assign combined = {high_i, low_i};
  assign shifted  = combined[{offset_i, 3'b000} +: 32];

  always_comb begin
    data_o = shifted;
    case (func3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: turns one load/store into one or two
// byte-strobed word requests on a REQ/ACK port and stalls until retired.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lsu_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  offset_q, offset_d;
  logic        split_q, split_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] low_q, low_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  // Decode of the instruction presented in IDLE.
  logic        req_valid;
  logic [2:0]  acc_f3;
  logic [3:0]  acc_mask;
  logic [1:0]  acc_off;
  logic        acc_split;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_strb;

  assign req_valid = lsu_valid_i & (mem_read_i | mem_write_i);
  assign acc_f3    = norm_func3(mem_write_i, func3_i);
  assign acc_mask  = size_mask(acc_f3);

  always_comb begin
    acc_off = address_i[1:0];
    if (!SPLIT_MISALIGNED) begin
      if (acc_mask == STRB_W)      acc_off = 2'b00;
      else if (acc_mask == STRB_H) acc_off = {address_i[1], 1'b0};
    end
  end

  assign acc_split = SPLIT_MISALIGNED &&
                     (((acc_mask == STRB_W) && (acc_off != 2'b00)) ||
                      ((acc_mask == STRB_H) && (acc_off == 2'b11)));
  assign acc_wdata = write_data_i << {acc_off, 3'b000};
  assign acc_strb  = acc_mask << acc_off;

  // Second beat carries the bytes that spilled past the first word.
  logic [5:0]  sec_wshift;
  logic [2:0]  sec_sshift;
  logic [31:0] sec_wdata;
  logic [3:0]  sec_strb;

  assign sec_wshift = 6'd32 - {1'b0, offset_q, 3'b000};
  assign sec_sshift = 3'd4 - {1'b0, offset_q};
  assign sec_wdata  = wdata_q >> sec_wshift;
  assign sec_strb   = size_mask(func3_q) >> sec_sshift;

  // On the first beat the read word is still on the bus; on the second it is the high word.
  logic [31:0] align_low;
  logic [31:0] align_data;

  assign align_low = (state_q == ST_FIRST) ? mem_rdata_i : low_q;

  lsu_load_align u_align (
    .high_i   (mem_rdata_i),
    .low_i    (align_low),
    .offset_i (offset_q),
    .func3_i  (func3_q),
    .data_o   (align_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    func3_d     = func3_q;
    offset_d    = offset_q;
    split_d     = split_q;
    wdata_d     = wdata_q;
    low_d       = low_q;
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_FIRST;
          we_d        = mem_write_i;
          func3_d     = acc_f3;
          offset_d    = acc_off;
          split_d     = acc_split;
          wdata_d     = write_data_i;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write_i;
          mem_addr_d  = {address_i[31:2], 2'b00};
          mem_wdata_d = acc_wdata;
          mem_wstrb_d = mem_write_i ? acc_strb : 4'b0000;
        end
      end
      ST_FIRST: begin
        if (mem_ack_i) begin
          low_d = mem_rdata_i;
          if (split_q) begin
            state_d     = ST_SECOND;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_wdata_d = sec_wdata;
            mem_wstrb_d = we_q ? sec_strb : 4'b0000;
          end else begin
            state_d   = ST_RESP;
            mem_req_d = 1'b0;
            if (!we_q) load_data_d = align_data;
          end
        end
      end
      ST_SECOND: begin
        if (mem_ack_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (!we_q) load_data_d = align_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      func3_q     <= 3'd0;
      offset_q    <= 2'd0;
      split_q     <= 1'b0;
      wdata_q     <= 32'd0;
      low_q       <= 32'd0;
      load_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      offset_q    <= offset_d;
      split_q     <= split_d;
      wdata_q     <= wdata_d;
      low_q       <= low_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign stall_o = !reset_i &&
                   (((state_q == ST_IDLE) && req_valid) ||
                    (state_q == ST_FIRST) || (state_q == ST_SECOND));
  assign done_o      = (state_q == ST_RESP);
  assign load_data_o = load_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/hold sequences and
// randomised accesses checked against a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] address, write_data;
  logic        stall, done;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .lsu_valid_i  (lsu_valid),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .func3_i      (func3),
    .address_i    (address),
    .write_data_i (write_data),
    .stall_o      (stall),
    .done_o       (done),
    .load_data_o  (load_data),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wstrb_o  (mem_wstrb),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  // Word memory seen over the bus, and an independent byte-level reference.
  logic [31:0] wmem [64];
  logic [7:0]  ref_mem [256];
  int          ack_delay = 0;
  bit          hold_ack = 1'b0;
  bit          noise_en = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_strb[$];
  logic        log_we[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: ACK after ack_delay wait cycles; strobed writes; spurious ACKs when idle.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !hold_ack) begin
        if (wait_cnt >= ack_delay) begin
          logic [5:0] idx;
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          idx       = mem_addr[7:2];
          mem_rdata = wmem[idx];
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) wmem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          log_addr.push_back(mem_addr);
          log_wdata.push_back(mem_wdata);
          log_strb.push_back(mem_wstrb);
          log_we.push_back(mem_we);
        end else begin
          wait_cnt++;
          mem_rdata = $urandom;
        end
      end else begin
        wait_cnt = 0;
        if (noise_en && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Presents one instruction and holds it until DONE; dcyc is the DONE cycle (-1 on timeout).
  task automatic run_op(input bit we, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] ld, output int dcyc, output int stall_bad);
    @(negedge clk);
    log_addr.delete(); log_wdata.delete(); log_strb.delete(); log_we.delete();
    lsu_valid  = 1'b1;
    mem_write  = we;
    mem_read   = !we || both;
    func3      = f3;
    address    = addr;
    write_data = wd;
    stall_bad  = 0;
    dcyc       = -1;
    ld         = 32'd0;
    #1;
    if (!stall) stall_bad++;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        ld   = load_data;
        dcyc = n;
        if (stall) stall_bad++;
        break;
      end else if (!stall) begin
        stall_bad++;
      end
    end
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    lsu_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  function automatic int nbytes(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(1'b0, f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(addr + i) & 32'hFF];
    if (f3 == 3'b000 && v[7])  v[31:8]  = '1;
    if (f3 == 3'b001 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = nbytes(1'b1, f3);
    for (int i = 0; i < n; i++) ref_mem[(addr + i) & 32'hFF] = wd[8*i +: 8];
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, w0, w1;
    int          dly, nb;
    logic [31:0] a0, a1;
    logic [3:0]  s0, s1;
    logic [31:0] d0, d1, ld;
    int          dn;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] ld;
    int dcyc, sbad, bad, nb, n;
    bit done_seen, we, both;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    logic [2:0] f3_pool[8];
    logic [5:0] i0, i1;

    //          we    f3      addr          wd            w0            w1         dly nb a0            a1          s0       s1       d0            d1          ld            dn
    vecs[0]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 32'h0,      0, 1, 32'h10,       32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'hDEADBEEF, 2};
    vecs[1]  = '{1'b1, 3'b000, 32'h13,       32'hA5,       32'h0,        32'h0,      0, 1, 32'h10,       32'h0,   4'b1000, 4'b0000, 32'hA5000000, 32'h0,      32'h0,        2};
    vecs[2]  = '{1'b0, 3'b000, 32'h21,       32'h0,        32'h8000,     32'h0,      0, 1, 32'h20,       32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'hFFFFFF80, 2};
    vecs[3]  = '{1'b0, 3'b100, 32'h21,       32'h0,        32'h8000,     32'h0,      0, 1, 32'h20,       32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'h00000080, 2};
    vecs[4]  = '{1'b1, 3'b010, 32'h102,      32'h11223344, 32'h0,        32'h0,      0, 2, 32'h100,      32'h104, 4'b1100, 4'b0011, 32'h33440000, 32'h1122,   32'h0,        3};
    vecs[5]  = '{1'b0, 3'b001, 32'h7,        32'h0,        32'hAB000000, 32'hCD,     2, 2, 32'h4,        32'h8,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'hFFFFCDAB, 7};
    vecs[6]  = '{1'b1, 3'b001, 32'h3,        32'hBEEF,     32'h0,        32'h0,      0, 2, 32'h0,        32'h4,   4'b1000, 4'b0001, 32'hEF000000, 32'hBE,     32'h0,        3};
    vecs[7]  = '{1'b0, 3'b101, 32'h2,        32'h0,        32'h81234567, 32'h0,      0, 1, 32'h0,        32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'h00008123, 2};
    vecs[8]  = '{1'b0, 3'b001, 32'h2,        32'h0,        32'h81234567, 32'h0,      1, 1, 32'h0,        32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'hFFFF8123, 3};
    vecs[9]  = '{1'b0, 3'b111, 32'h8,        32'h0,        32'h12345678, 32'h0,      0, 1, 32'h8,        32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'h12345678, 2};
    vecs[10] = '{1'b1, 3'b100, 32'h30,       32'hCAFEF00D, 32'h0,        32'h0,      0, 1, 32'h30,       32'h0,   4'b1111, 4'b0000, 32'hCAFEF00D, 32'h0,      32'h0,        2};
    vecs[11] = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        32'h55660000, 32'h7788,   0, 2, 32'hFFFFFFFC, 32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,      32'h77885566, 3};

    f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 64; i++) wmem[i] = 32'd0;

    // Reset state, with an access being presented to prove STALL is forced low.
    reset = 1'b1; lsu_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    func3 = 3'b010; address = 32'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_ctl", {29'd0, mem_req, mem_we, done}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("reset_ldata", load_data, 32'd0);
    reset = 1'b0; lsu_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    noise_en = 1'b1;

    foreach (vecs[v]) begin
      i0 = vecs[v].addr[7:2];
      i1 = i0 + 6'd1;
      wmem[i0] = vecs[v].w0;
      wmem[i1] = vecs[v].w1;
      ack_delay = vecs[v].dly;
      run_op(vecs[v].we, 1'b0, vecs[v].f3, vecs[v].addr, vecs[v].wd, ld, dcyc, sbad);
      $display("vec %0d: we=%0b f3=%b addr=%08h done@%0d beats=%0d ld=%08h",
               v, vecs[v].we, vecs[v].f3, vecs[v].addr, dcyc, log_addr.size(), ld);
      chk($sformatf("vec%0d_done_cycle", v), dcyc, vecs[v].dn);
      chk($sformatf("vec%0d_stall", v), sbad, 0);
      chk($sformatf("vec%0d_beats", v), log_addr.size(), vecs[v].nb);
      if (log_addr.size() >= 1) begin
        chk($sformatf("vec%0d_addr0", v), log_addr[0], vecs[v].a0);
        chk($sformatf("vec%0d_strb0", v), {28'd0, log_strb[0]}, {28'd0, vecs[v].s0});
        chk($sformatf("vec%0d_we0", v), {31'd0, log_we[0]}, {31'd0, vecs[v].we});
        if (vecs[v].we) chk($sformatf("vec%0d_wdata0", v), log_wdata[0], vecs[v].d0);
      end
      if (vecs[v].nb == 2 && log_addr.size() >= 2) begin
        chk($sformatf("vec%0d_addr1", v), log_addr[1], vecs[v].a1);
        chk($sformatf("vec%0d_strb1", v), {28'd0, log_strb[1]}, {28'd0, vecs[v].s1});
        if (vecs[v].we) chk($sformatf("vec%0d_wdata1", v), log_wdata[1], vecs[v].d1);
      end
      if (!vecs[v].we) chk($sformatf("vec%0d_load", v), ld, vecs[v].ld);
    end
    go_idle(2);

    // Reset while the first beat is waiting for ACK: request dropped, no DONE.
    noise_en = 1'b0;
    hold_ack = 1'b1;
    lsu_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; address = 32'h40;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; lsu_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("rst_mid_stall_forced", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("rst_mid_req_after", {31'd0, mem_req}, 32'd0);
    reset = 1'b0; hold_ack = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
    $display("reset-abandon sequence: req dropped, done_seen=%0b", done_seen);

    wmem[16] = 32'h0BADF00D;
    ack_delay = 0;
    run_op(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, ld, dcyc, sbad);
    $display("post-reset LW 0x40: done@%0d ld=%08h", dcyc, ld);
    chk("post_rst_done_cycle", dcyc, 2);
    chk("post_rst_load", ld, 32'h0BADF00D);
    go_idle(4);
    chk("ldata_hold", load_data, 32'h0BADF00D);

    // Randomised accesses against the byte-level reference.
    noise_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wmem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = wmem[i][8*b +: 8];
    end
    for (int t = 0; t < 200; t++) begin
      we   = 1'($urandom_range(0, 1));
      both = we && ($urandom_range(0, 3) == 0);
      f3   = f3_pool[$urandom_range(0, 7)];
      addr = $urandom;
      wd   = $urandom;
      ack_delay = $urandom_range(0, 2);
      n  = nbytes(we, f3);
      nb = ((addr & 32'd3) + n > 4) ? 2 : 1;
      run_op(we, both, f3, addr, wd, ld, dcyc, sbad);
      $display("rnd %0d: we=%0b f3=%b addr=%08h wd=%08h dly=%0d done@%0d ld=%08h",
               t, we, f3, addr, wd, ack_delay, dcyc, ld);
      chk($sformatf("rnd%0d_done_cycle", t), dcyc, 1 + nb * (ack_delay + 1));
      chk($sformatf("rnd%0d_beats", t), log_addr.size(), nb);
      chk($sformatf("rnd%0d_stall", t), sbad, 0);
      if (we) ref_store(f3, addr, wd);
      else    chk($sformatf("rnd%0d_load", t), ld, ref_load(f3, addr));
    end
    go_idle(2);

    bad = 0;
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++)
        if (wmem[i][8*b +: 8] !== ref_mem[4*i + b]) bad++;
    chk("mem_image_bytes_differing", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
